// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Default geometry plus pointer/count width helpers used by the FIFO modules.
package fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

    // Count needs one extra bit so that "full" (ct == DEPTH) is representable.
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the FIFO.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
);

    logic             wt_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wt_en, rd_en, din,
        input  dout, full, empty, overflow, underflow
    );

    modport slave (
        input  wt_en, rd_en, din,
        output dout, full, empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array with a synchronous write port and a registered read port.
// The read data register is the FIFO's dout and holds its value when no read is accepted.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FIFO_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is never reset; its contents are irrelevant until written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_rtl.sv
// Synchronous single-clock FIFO: pointers, occupancy count and error flags around fifo_mem.
// full/empty decode the registered count, so no input reaches an output combinationally.
module fifo_rtl
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    fifo_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cntWidth(DEPTH);

    logic [PW-1:0] wt_p, wt_p_d;
    logic [PW-1:0] rd_p, rd_p_d;
    logic [CW-1:0] ct, ct_d;
    logic          overflow_q, underflow_q;
    logic          wrAccept, rdAccept;

    assign bus.full  = (ct == CW'(DEPTH));
    assign bus.empty = (ct == '0);

    // Full blocks writes and empty blocks reads even when the other side is active.
    assign wrAccept = bus.wt_en && !bus.full;
    assign rdAccept = bus.rd_en && !bus.empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wt_p_d = wt_p;
        rd_p_d = rd_p;
        ct_d   = ct;
        if (wrAccept) begin
            wt_p_d = wt_p + PW'(1);
        end
        if (rdAccept) begin
            rd_p_d = rd_p + PW'(1);
        end
        case ({wrAccept, rdAccept})
            2'b10:   ct_d = ct + CW'(1);
            2'b01:   ct_d = ct - CW'(1);
            default: ct_d = ct;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wt_p        <= '0;
            rd_p        <= '0;
            ct          <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wt_p        <= wt_p_d;
            rd_p        <= rd_p_d;
            ct          <= ct_d;
            overflow_q  <= bus.wt_en && bus.full;
            underflow_q <= bus.rd_en && bus.empty;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wrAccept),
        .wr_addr_i (wt_p),
        .wr_data_i (bus.din),
        .rd_en_i   (rdAccept),
        .rd_addr_i (rd_p),
        .rd_data_o (bus.dout)
    );

endmodule

// File: tb/tb_fifo_rtl.sv
// Self-checking bench for fifo_rtl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fifo_rtl;
    import fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_if #(.WIDTH(WIDTH)) bus ();

    fifo_rtl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the FIFO is just an ordered queue plus a few expected registers.
    logic [WIDTH-1:0] modelQ[$];
    logic [WIDTH-1:0] expDout;
    logic             expOvf;
    logic             expUnf;
    int               wrTotal;
    int               rdTotal;

    int vectorCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expDout = '0;
        expOvf  = 1'b0;
        expUnf  = 1'b0;
        wrTotal = 0;
        rdTotal = 0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".dout"},      32'(bus.dout),      32'(expDout));
        checkOutput({tag, ".full"},      32'(bus.full),      32'(modelQ.size() == DEPTH));
        checkOutput({tag, ".empty"},     32'(bus.empty),     32'(modelQ.size() == 0));
        checkOutput({tag, ".overflow"},  32'(bus.overflow),  32'(expOvf));
        checkOutput({tag, ".underflow"}, 32'(bus.underflow), 32'(expUnf));
        checkOutput({tag, ".ct"},        32'(dut.ct),        32'(modelQ.size()));
        checkOutput({tag, ".wt_p"},      32'(dut.wt_p),      32'(wrTotal % DEPTH));
        checkOutput({tag, ".rd_p"},      32'(dut.rd_p),      32'(rdTotal % DEPTH));
    endtask

    // One clock of stimulus: drive on the falling edge, update the model at the
    // rising edge, then compare just after it.
    task automatic applyStimulus(input string tag, input logic wt, input logic rd,
                                 input logic [WIDTH-1:0] data);
        bit preFull, preEmpty;
        @(negedge clk);
        bus.wt_en = wt;
        bus.rd_en = rd;
        bus.din   = data;
        @(posedge clk);
        preFull  = (modelQ.size() == DEPTH);
        preEmpty = (modelQ.size() == 0);
        expOvf   = wt && preFull;
        expUnf   = rd && preEmpty;
        if (rd && !preEmpty) begin
            expDout = modelQ.pop_front();
            rdTotal++;
        end
        if (wt && !preFull) begin
            modelQ.push_back(data);
            wrTotal++;
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        rst       = 1'b0;
        bus.wt_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        modelReset();

        // Reset held for 10 ns, released away from the rising edge
        #8;
        checkAll("rst_hold");
        #2;
        rst = 1'b1;
        #1;
        checkAll("rst_rel");

        // Write two words then read them back
        applyStimulus("wr04", 1'b1, 1'b0, 8'h04);
        applyStimulus("wr05", 1'b1, 1'b0, 8'h05);
        checkOutput("wt_p_after_two", 32'(dut.wt_p), 32'd2);
        applyStimulus("rd04", 1'b0, 1'b1, 8'h00);
        checkOutput("dout_first", 32'(bus.dout), 32'h04);
        applyStimulus("rd05", 1'b0, 1'b1, 8'h00);
        checkOutput("dout_second", 32'(bus.dout), 32'h05);
        checkOutput("empty_after_reads", 32'(bus.empty), 32'd1);

        // Reads on an empty FIFO
        for (int i = 0; i < 6; i++) begin
            applyStimulus("underflow", 1'b0, 1'b1, 8'hEE);
        end
        checkOutput("underflow_held", 32'(bus.underflow), 32'd1);
        applyStimulus("underflow_clr", 1'b0, 1'b0, 8'h00);
        checkOutput("underflow_cleared", 32'(bus.underflow), 32'd0);

        // Fill to DEPTH, attempt one more write, drain
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("fill", 1'b1, 1'b0, 8'(8'h10 + i));
        end
        checkOutput("full_at_depth", 32'(bus.full), 32'd1);
        applyStimulus("overflow", 1'b1, 1'b0, 8'hAA);
        checkOutput("overflow_set", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("drain", 1'b0, 1'b1, 8'h00);
            checkOutput("drain_order", 32'(bus.dout), 32'(8'h10 + i));
        end

        // Concurrent read/write at a mid-level occupancy
        for (int i = 0; i < 5; i++) begin
            applyStimulus("pre5", 1'b1, 1'b0, 8'(8'h30 + i));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus("both_mid", 1'b1, 1'b1, 8'(8'h40 + i));
        end
        checkOutput("ct_stays_5", 32'(dut.ct), 32'd5);

        // Both enables while full: read wins, write is rejected
        while (modelQ.size() < DEPTH) begin
            applyStimulus("topup", 1'b1, 1'b0, 8'($urandom));
        end
        applyStimulus("both_full", 1'b1, 1'b1, 8'h99);
        checkOutput("ct_after_both_full", 32'(dut.ct), 32'd15);
        checkOutput("ovf_after_both_full", 32'(bus.overflow), 32'd1);

        // Drain to 8 entries, then assert reset mid-stream between clock edges
        while (modelQ.size() > 8) begin
            applyStimulus("to8", 1'b0, 1'b1, 8'h00);
        end
        @(negedge clk);
        bus.wt_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 8'h77;
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkAll("async_rst");
        @(negedge clk);
        bus.wt_en = 1'b0;
        bus.rd_en = 1'b0;
        checkAll("rst_low_edge");
        rst = 1'b1;
        applyStimulus("post_rst_wr", 1'b1, 1'b0, 8'h5A);
        applyStimulus("post_rst_rd", 1'b0, 1'b1, 8'h00);
        checkOutput("post_rst_data", 32'(bus.dout), 32'h5A);

        // Random traffic with a varying write/read bias to visit full and empty
        for (int blk = 0; blk < 8; blk++) begin
            int wtBias;
            int rdBias;
            wtBias = (blk % 2 == 0) ? 80 : 25;
            rdBias = (blk % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 80; i++) begin
                applyStimulus("random",
                              $urandom_range(0, 99) < wtBias,
                              $urandom_range(0, 99) < rdBias,
                              8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
